median5_stream: RTL

MEDIAN5_STREAM -- requirements
Module: median5_stream

---
 rtl/median5_stream.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/median5_stream.sv
// Streaming 5-tap median filter with impulse-noise flagging.
// Each line of samples fills a 5-entry window; once full, every accepted
// sample produces the median of the newest five samples, the window centre
// (third-newest sample) and a flag marking the centre as an outlier.
module median5_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_median,
  output logic [DATA_WIDTH-1:0] out_center,
  output logic                  out_noise,
  output logic                  out_last,
  output logic                  err_short
);

  typedef enum logic [0:0] {FILL, RUN} state_t;

  state_t state, state_next;
  logic [2:0] cnt, cnt_next;

  // Window entry 0 is the newest sample, entry 4 the oldest.
  logic [4:0][DATA_WIDTH-1:0] win;
  logic [4:0][DATA_WIDTH-1:0] win_upd;
  logic [4:0][DATA_WIDTH-1:0] sorted;

  logic accept;
  logic load;
  logic short_end;
  logic noise;

  // Odd-even transposition network; five rounds fully sort five values.
  function automatic logic [4:0][DATA_WIDTH-1:0] sort5(
    input logic [4:0][DATA_WIDTH-1:0] v
  );
    logic [4:0][DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0]      t;
    s = v;
    for (int r = 0; r < 5; r++) begin
      for (int i = r % 2; i < 4; i += 2) begin
        if (s[i] > s[i+1]) begin
          t      = s[i];
          s[i]   = s[i+1];
          s[i+1] = t;
        end
      end
    end
    return s;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Window as it will look after this accept: new sample plus four newest.
  assign win_upd = {win[3:0], in_data};

  // Sort the updated window and flag the centre when it is an extreme value.
  always_comb begin
    sorted = sort5(win_upd);
    noise  = ((win[1] == sorted[0]) || (win[1] == sorted[4])) &&
             (sorted[0] != sorted[4]);
  end

  // Line-fill state machine: decides when a result is produced.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    short_end  = 1'b0;
    if (accept) begin
      unique case (state)
        FILL: begin
          if (cnt == 3'd4) begin
            load = 1'b1;
            if (in_last) begin
              state_next = FILL;
              cnt_next   = 3'd0;
            end else begin
              state_next = RUN;
            end
          end else if (in_last) begin
            short_end = 1'b1;
            cnt_next  = 3'd0;
          end else begin
            cnt_next = cnt + 3'd1;
          end
        end
        RUN: begin
          load = 1'b1;
          if (in_last) begin
            state_next = FILL;
            cnt_next   = 3'd0;
          end
        end
        default: begin
          state_next = FILL;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // Control state, window shift and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= 3'd0;
      win        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_noise  <= 1'b0;
      out_median <= '0;
      out_center <= '0;
      err_short  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      err_short <= short_end;
      if (accept) begin
        win <= win_upd;
      end
      // Output stage: load on a producing accept, otherwise drain on ready.
      if (load) begin
        out_valid  <= 1'b1;
        out_median <= sorted[2];
        out_center <= win[1];
        out_noise  <= noise;
        out_last   <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
